// File: rtl/mux_2to1.sv
// Two-source selector with a zero-latency output and a registered, valid-qualified output.
// Latency: y_comb 0 cycles; y / y_sel / out_valid 1 cycle after the capturing edge.
// No backpressure: one capture per cycle, no stall input; the consumer must keep up.
module mux_2to1 #(
  parameter int unsigned WIDTH           = 1,  // legal 1..64
  parameter bit          HOLD_ON_INVALID = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  input  logic             in_valid,
  output logic [WIDTH-1:0] y_comb,
  output logic [WIDTH-1:0] y,
  output logic             out_valid,
  output logic             y_sel
);

  // When holding is disabled the data flops load every cycle; only out_valid
  // still reflects in_valid.
  localparam bit TRACK_ALWAYS = (HOLD_ON_INVALID == 1'b0);

  logic [WIDTH-1:0] sel_dat;
  logic             load_en;

  logic [WIDTH-1:0] y_q,         y_d;
  logic             y_sel_q,     y_sel_d;
  logic             out_valid_q, out_valid_d;

  // Ternary select keeps simulation X-merge: with an unknown sel, bits where
  // a and b agree resolve, differing bits go X.
  assign sel_dat = sel ? b : a;
  assign y_comb  = sel_dat;

  assign load_en = in_valid | TRACK_ALWAYS;

  // Next-state: load the selection when enabled, otherwise hold.
  always_comb begin
    y_d         = y_q;
    y_sel_d     = y_sel_q;
    out_valid_d = in_valid;
    if (load_en) begin
      y_d     = sel_dat;
      y_sel_d = sel;
    end
  end

  // Output flops; reset clears them immediately and wins over any capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q         <= '0;
      y_sel_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      y_q         <= y_d;
      y_sel_q     <= y_sel_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign y         = y_q;
  assign y_sel     = y_sel_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_2to1.sv
// Directed bench for mux_2to1: truth table at WIDTH=1, capture/hold/track/reset at WIDTH=8.
// Latency: checks registered outputs one edge after the capturing edge.
// No backpressure in the DUT; stimulus is driven on the falling edge.
module tb_mux_2to1;

  logic       clk;
  logic       rst_n;

  // WIDTH=1 instance for the exhaustive combinational table
  logic [0:0] a1, b1, yc1, y1;
  logic       sel1, vld1, ov1, ys1;

  // WIDTH=8 instances, hold and track variants, sharing stimulus
  logic [7:0] a8, b8;
  logic       sel8, vld8;
  logic [7:0] yc_h, y_h, yc_t, y_t;
  logic       ov_h, ys_h, ov_t, ys_t;

  int n_checks;
  int n_pass;

  mux_2to1 #(.WIDTH(1), .HOLD_ON_INVALID(1'b1)) dut_w1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .sel(sel1), .in_valid(vld1),
    .y_comb(yc1), .y(y1), .out_valid(ov1), .y_sel(ys1)
  );

  mux_2to1 #(.WIDTH(8), .HOLD_ON_INVALID(1'b1)) dut_hold (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .sel(sel8), .in_valid(vld8),
    .y_comb(yc_h), .y(y_h), .out_valid(ov_h), .y_sel(ys_h)
  );

  mux_2to1 #(.WIDTH(8), .HOLD_ON_INVALID(1'b0)) dut_track (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .sel(sel8), .in_valid(vld8),
    .y_comb(yc_t), .y(y_t), .out_valid(ov_t), .y_sel(ys_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  initial begin
    logic [7:0] tt;
    n_checks = 0;
    n_pass   = 0;
    // expected y_comb indexed by {a,b,sel}: 000..111 -> 0,0,0,1,1,0,1,1
    tt = 8'hD8;

    rst_n = 1'b0;
    a1 = '0; b1 = '0; sel1 = 1'b0; vld1 = 1'b0;
    a8 = '0; b8 = '0; sel8 = 1'b0; vld8 = 1'b0;

    // reset values before any clock edge
    #2;
    check("rst_y",         {56'd0, y_h}, 64'h0);
    check("rst_y_sel",     {63'd0, ys_h}, 64'h0);
    check("rst_out_valid", {63'd0, ov_h}, 64'h0);

    // exhaustive WIDTH=1 truth table, 10-unit steps
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = i[2:0];
      a1 = v[2]; b1 = v[1]; sel1 = v[0];
      #10;
      check($sformatf("tt_%0d%0d%0d", v[2], v[1], v[0]), {63'd0, yc1}, {63'd0, tt[i]});
    end

    // reset asserted across an edge with valid input: no capture
    @(negedge clk);
    a8 = 8'h3C; b8 = 8'hA5; sel8 = 1'b1; vld8 = 1'b1;
    @(negedge clk);
    check("rst_override_y",  {56'd0, y_h}, 64'h0);
    check("rst_override_ov", {63'd0, ov_h}, 64'h0);

    // release, then back-to-back capture sel=1 then sel=0
    rst_n = 1'b1;
    @(negedge clk);
    check("cap1_y",     {56'd0, y_h}, 64'hA5);
    check("cap1_y_sel", {63'd0, ys_h}, 64'h1);
    check("cap1_ov",    {63'd0, ov_h}, 64'h1);
    sel8 = 1'b0;
    @(negedge clk);
    check("cap2_y",     {56'd0, y_h}, 64'h3C);
    check("cap2_y_sel", {63'd0, ys_h}, 64'h0);
    check("cap2_ov",    {63'd0, ov_h}, 64'h1);
    check("cap2_y_trk", {56'd0, y_t}, 64'h3C);

    // hold vs track when in_valid drops
    sel8 = 1'b1;
    @(negedge clk);
    check("pre_hold_y", {56'd0, y_h}, 64'hA5);
    vld8 = 1'b0; a8 = 8'hFF; sel8 = 1'b0;
    #1;
    check("hold_y_comb", {56'd0, yc_h}, 64'hFF);
    @(negedge clk);
    check("hold_y",       {56'd0, y_h}, 64'hA5);
    check("hold_y_sel",   {63'd0, ys_h}, 64'h1);
    check("hold_ov",      {63'd0, ov_h}, 64'h0);
    check("track_y",      {56'd0, y_t}, 64'hFF);
    check("track_y_sel",  {63'd0, ys_t}, 64'h0);
    check("track_ov",     {63'd0, ov_t}, 64'h0);

    // asynchronous reset between edges
    vld8 = 1'b1; sel8 = 1'b1; b8 = 8'hA5;
    @(negedge clk);
    check("pre_arst_y", {56'd0, y_h}, 64'hA5);
    vld8 = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_y",     {56'd0, y_h}, 64'h0);
    check("arst_y_sel", {63'd0, ys_h}, 64'h0);
    check("arst_ov",    {63'd0, ov_h}, 64'h0);
    check("arst_y_comb", {56'd0, yc_h}, 64'hA5);
    @(negedge clk);
    rst_n = 1'b1;
    b8 = 8'h11; sel8 = 1'b1; vld8 = 1'b1;
    @(negedge clk);
    check("post_arst_y",  {56'd0, y_h}, 64'h11);
    check("post_arst_ov", {63'd0, ov_h}, 64'h1);

    // equal inputs, sel toggling every cycle
    a8 = 8'h5A; b8 = 8'h5A;
    for (int i = 0; i < 4; i++) begin
      sel8 = i[0];
      #1;
      check($sformatf("eq_y_comb_%0d", i), {56'd0, yc_h}, 64'h5A);
      @(negedge clk);
      check($sformatf("eq_y_%0d", i), {56'd0, y_h}, 64'h5A);
      check($sformatf("eq_y_sel_%0d", i), {63'd0, ys_h}, {63'd0, i[0]});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
